// File: rtl/fpa64_pkg.sv
// Shared widths and constants for the pipelined 64-bit floating-point adder.
package fpa64_pkg;

  localparam int MANT_W    = 54;
  localparam int EXP_W     = 11;
  localparam int GRS_W     = 3;
  localparam int FULL_W    = 57;
  localparam int DIFF_W    = EXP_W + 1;
  localparam int SHIFT_SAT = 57;

endpackage

// File: rtl/fpa64_sticky_shift.sv
// Combinational right shift of the extended small mantissa; every bit pushed past
// position 0 is ORed into the LSB, and shifts of SHIFT_SAT or more collapse to sticky.
module fpa64_sticky_shift
  import fpa64_pkg::*;
(
  input  logic [FULL_W-1:0] data,
  input  logic [DIFF_W-1:0] shamt,
  output logic [FULL_W-1:0] result
);

  logic [FULL_W-1:0] shifted;
  logic [FULL_W-1:0] lost_mask;

  always_comb begin
    shifted   = data >> shamt;
    lost_mask = ~({FULL_W{1'b1}} << shamt);
    result    = shifted;
    if (shamt >= DIFF_W'(SHIFT_SAT)) begin
      result = {{(FULL_W-1){1'b0}}, |data};
    end else begin
      result[0] = shifted[0] | (|(data & lost_mask));
    end
  end

endmodule

// File: rtl/fpa64_align_stage.sv
// Alignment stage of the FP64 adder: S1 orders operands by exponent and forms the
// exponent difference, S2 shifts the smaller mantissa with guard/round/sticky.
module fpa64_align_stage
  import fpa64_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] bigreg,
  input  logic [MANT_W-1:0] smallreg,
  input  logic [EXP_W-1:0]  bigshift,
  input  logic [EXP_W-1:0]  smallshift,
  input  logic              resultsign,
  input  logic              eff_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FULL_W-1:0] big_mant,
  output logic [FULL_W-1:0] small_mant,
  output logic [EXP_W-1:0]  res_exp,
  output logic              res_sign,
  output logic              res_sub,
  output logic              swapped
);

  logic              s1_valid;
  logic [MANT_W-1:0] s1_big;
  logic [MANT_W-1:0] s1_small;
  logic [EXP_W-1:0]  s1_exp;
  logic [DIFF_W-1:0] s1_diff;
  logic              s1_sign;
  logic              s1_sub;
  logic              s1_swapped;

  logic              do_swap;
  logic [MANT_W-1:0] hi_mant;
  logic [MANT_W-1:0] lo_mant;
  logic [EXP_W-1:0]  hi_exp;
  logic [EXP_W-1:0]  lo_exp;
  logic [DIFF_W-1:0] diff;

  logic              s2_accept;
  logic              s1_load;
  logic              s2_load;
  logic [FULL_W-1:0] aligned;

  // in_ready depends only on pipeline state and out_ready, never on in_valid.
  assign s2_accept = !out_valid || out_ready;
  assign in_ready  = !s1_valid || s2_accept;
  assign s1_load   = in_valid && in_ready;
  assign s2_load   = s1_valid && s2_accept;

  always_comb begin
    do_swap = $signed(smallshift) > $signed(bigshift);
    hi_mant = bigreg;
    lo_mant = smallreg;
    hi_exp  = bigshift;
    lo_exp  = smallshift;
    if (do_swap) begin
      hi_mant = smallreg;
      lo_mant = bigreg;
      hi_exp  = smallshift;
      lo_exp  = bigshift;
    end
    // Sign-extended to 12 bits the difference is always non-negative here.
    diff = {hi_exp[EXP_W-1], hi_exp} - {lo_exp[EXP_W-1], lo_exp};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid   <= 1'b0;
      s1_big     <= '0;
      s1_small   <= '0;
      s1_exp     <= '0;
      s1_diff    <= '0;
      s1_sign    <= 1'b0;
      s1_sub     <= 1'b0;
      s1_swapped <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid   <= 1'b1;
        s1_big     <= hi_mant;
        s1_small   <= lo_mant;
        s1_exp     <= hi_exp;
        s1_diff    <= diff;
        s1_sign    <= resultsign;
        s1_sub     <= eff_sub;
        s1_swapped <= do_swap;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  fpa64_sticky_shift u_shift (
    .data   ({s1_small, {GRS_W{1'b0}}}),
    .shamt  (s1_diff),
    .result (aligned)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      big_mant   <= '0;
      small_mant <= '0;
      res_exp    <= '0;
      res_sign   <= 1'b0;
      res_sub    <= 1'b0;
      swapped    <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid  <= 1'b1;
        big_mant   <= {s1_big, {GRS_W{1'b0}}};
        small_mant <= aligned;
        res_exp    <= s1_exp;
        res_sign   <= s1_sign;
        res_sub    <= s1_sub;
        swapped    <= s1_swapped;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fpa64_align_stage.md
Name: fpa64_align_stage

Overview:
- Second stage of the pipelined 64-bit floating-point adder. Consumes the operand-ordering stage's outputs: the 54-bit mantissas with the hidden bit inserted, the unbiased exponents, the result sign and the effective-operation flag.
- Swaps the operands if the small exponent exceeds the big one; the same-sign path upstream does not order them.
- Right-shifts the smaller mantissa by the exponent difference and appends guard/round/sticky bits.
- Delivers aligned operands to the add/subtract stage through a 2-deep valid/ready pipeline.

Parameters:
- MANT_W, 54, mantissa width from upstream: {1'b0, hidden 1, 52-bit fraction}.
- EXP_W, 11, unbiased exponent width, two's complement.
- GRS_W, 3, guard/round/sticky extension bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input operand set valid.
- in_ready  out  1  stage can accept an input this cycle.
- bigreg  in  54  mantissa of the nominally larger operand.
- smallreg  in  54  mantissa of the nominally smaller operand.
- bigshift  in  11  unbiased exponent of bigreg (signed).
- smallshift  in  11  unbiased exponent of smallreg (signed).
- resultsign  in  1  sign of the result.
- eff_sub  in  1  effective subtraction (operand signs differ).
- out_valid  out  1  aligned set valid.
- out_ready  in  1  downstream accepts this cycle.
- big_mant  out  57  {bigreg after swap, 3'b000}.
- small_mant  out  57  {aligned small mantissa, guard, round, sticky}.
- res_exp  out  11  common exponent = larger of the two inputs (signed).
- res_sign  out  1  resultsign, passed through.
- res_sub  out  1  eff_sub, passed through.
- swapped  out  1  1 if stage 1 exchanged the operands.

Behaviour:
- Reset (rst=0, async): all pipeline valid bits = 0; out_valid=0; all data outputs = 0. in_ready=1 from the first edge after reset release.
- Handshake: transfer on valid&&ready at both ends.
  - S1 loads when in_valid && in_ready. S2 loads from S1 when S1 is valid and S2 is empty or S2 is draining (out_ready).
  - in_ready = !s1_valid || s2 will accept. This is combinational from out_ready, with no combinational path from in_valid.
  - Data is held stable while out_valid && !out_ready.
- Latency: 2 cycles from input acceptance to out_valid when unstalled. Throughput is 1 set per cycle.
- S1 (compare/swap):
  - Signed compare of bigshift vs smallshift.
  - If smallshift > bigshift: exchange mantissas and exponents, swapped=1.
  - Equal exponents: no swap.
  - diff = larger − smaller, computed in 12-bit signed and stored as 12-bit unsigned (0..2046).
  - Register: big mantissa, small mantissa, larger exponent, diff, sign, eff_sub, swapped.
- S2 (align):
  - ext = {small, 3'b000} (57 bits).
  - If diff ≤ 56: shifted = ext >> diff. Sticky = OR of all bits shifted out of position 0, ORed with the shifted value's bit 0.
  - If diff ≥ 57: small_mant = {56'b0, |small}.
  - big_mant = {big, 3'b000}.
- Sticky is never lost: any nonzero bit shifted past the LSB forces small_mant[0]=1.
- resultsign and eff_sub pass through unchanged; the swap does not alter them.
- Exponent inputs of 1024 (biased 2047, Inf/NaN) are unsupported. Outputs are don't-care but the pipeline must not stall or hang.
- Simultaneous accept into S1 and drain of S2 in one cycle: no bubble inserted, no data lost.
- rst asserted mid-stall: in-flight data discarded, valids cleared immediately.

Decomposition:
- Shared package fpa64_pkg: MANT_W, EXP_W, GRS_W, FULL_W=57, and the shift-saturation constant 57.
- One sub-module: fpa64_sticky_shift. Purely combinational; 57-bit right shift with sticky collapse, saturating at 57. Instantiated in S2.

Test Plan:
- 1.0+1.0: bigreg=smallreg=54'h10000000000000, shifts=0, eff_sub=0 -> after 2 cycles out_valid=1, big_mant=small_mant=57'h080000000000000, res_exp=0, swapped=0.
- Swap: bigshift=−2 (11'h7FE), smallshift=3, same mantissas -> swapped=1, res_exp=3, small_mant=57'h080000000000000>>5=57'h004000000000000, sticky=0.
- Sticky: smallreg=54'h10000000000001, diff=4 -> the mantissa's bit 0 is shifted out; small_mant[0]=1.
- Saturation: diff=60, smallreg nonzero -> small_mant=57'h1. Same with diff=56 -> small_mant[0]=1, all other bits 0.
- Backpressure: stream 4 sets with out_ready=0 for 5 cycles -> in_ready falls after 2 accepts. On release, outputs come in order with no duplicates or drops, 1 per cycle.
- Reset: assert rst=0 while 2 sets are in flight and stalled -> out_valid=0 at once; after release, the next input appears 2 cycles after acceptance.
